// File: rtl/usr_shift_sequencer_if.sv
// Command, response and shift-register control bundle for usr_shift_sequencer.
// master is the sequencer's view; slave is the command source, consumer and register side.
interface usr_shift_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [2:0] cmd_count;
    logic       cmd_fill;

    logic [1:0] usr_select;
    logic [3:0] usr_parallel_in;
    logic       usr_shift_right;
    logic       usr_shift_left;
    logic [3:0] usr_data_out;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;

    modport master (
        input  cmd_valid, cmd_op, cmd_data, cmd_count, cmd_fill,
        output cmd_ready,
        output usr_select, usr_parallel_in, usr_shift_right, usr_shift_left,
        input  usr_data_out,
        output rsp_valid, rsp_data,
        input  rsp_ready
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_data, cmd_count, cmd_fill,
        input  cmd_ready,
        input  usr_select, usr_parallel_in, usr_shift_right, usr_shift_left,
        output usr_data_out,
        input  rsp_valid, rsp_data,
        output rsp_ready
    );
endinterface

// File: rtl/usr_shift_sequencer.sv
// Sequences one shift/rotate command onto a 4-bit universal shift register:
// parallel load, N shift steps, then hands the register contents back as a response.
module usr_shift_sequencer (
    input  logic                  clk,
    input  logic                  reset,
    usr_shift_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    typedef enum logic [1:0] {
        OP_SHR = 2'b00,
        OP_SHL = 2'b01,
        OP_ROR = 2'b10,
        OP_ROL = 2'b11
    } op_t;

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_RIGHT = 2'b01;
    localparam logic [1:0] SEL_LEFT  = 2'b10;
    localparam logic [1:0] SEL_LOAD  = 2'b11;

    state_t     state_q, state_d;
    op_t        op_q;
    logic [3:0] data_q;
    logic [2:0] count_q;
    logic       fill_q;
    logic [2:0] remaining_q;
    logic       accept;

    assign accept = bus.cmd_valid && bus.cmd_ready;

    always_ff @(posedge clk) begin
        // NOTE: state is updated with <= so every register samples the pre-edge values of its peers.
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            op_q        <= OP_SHR;
            data_q      <= '0;
            count_q     <= '0;
            fill_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= op_t'(bus.cmd_op);
                data_q  <= bus.cmd_data;
                count_q <= bus.cmd_count;
                fill_q  <= bus.cmd_fill;
            end
            if (state_q == LOAD) begin
                remaining_q <= count_q;
            end else if (state_q == SHIFT) begin
                remaining_q <= remaining_q - 3'd1;
            end
        end
    end

    // Every output is forced low while reset is asserted, independent of the state register.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
        state_d             = state_q;
        bus.cmd_ready       = 1'b0;
        bus.usr_select      = SEL_HOLD;
        bus.usr_parallel_in = '0;
        bus.usr_shift_right = 1'b0;
        bus.usr_shift_left  = 1'b0;
        bus.rsp_valid       = 1'b0;
        bus.rsp_data        = '0;

        if (!reset) begin
            case (state_q)
                IDLE: begin
                    bus.cmd_ready = 1'b1;
                    if (bus.cmd_valid) state_d = LOAD;
                end
                LOAD: begin
                    bus.usr_select      = SEL_LOAD;
                    bus.usr_parallel_in = data_q;
                    state_d             = (count_q != 3'd0) ? SHIFT : DONE;
                end
                SHIFT: begin
                    // Rotates feed the bit falling off one end straight back into the other.
                    case (op_q)
                        OP_SHR: begin
                            bus.usr_select      = SEL_RIGHT;
                            bus.usr_shift_right = fill_q;
                        end
                        OP_SHL: begin
                            bus.usr_select     = SEL_LEFT;
                            bus.usr_shift_left = fill_q;
                        end
                        OP_ROR: begin
                            bus.usr_select      = SEL_RIGHT;
                            bus.usr_shift_right = bus.usr_data_out[0];
                        end
                        OP_ROL: begin
                            bus.usr_select     = SEL_LEFT;
                            bus.usr_shift_left = bus.usr_data_out[3];
                        end
                        default: ;
                    endcase
                    if (remaining_q == 3'd1) state_d = DONE;
                end
                DONE: begin
                    bus.rsp_valid = 1'b1;
                    bus.rsp_data  = bus.usr_data_out;
                    if (bus.rsp_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Self-checking bench for usr_shift_sequencer with a behavioural 4-bit universal shift register
// and an arithmetic reference model of the shift/rotate commands.
module tb_usr_shift_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    usr_shift_sequencer_if bus ();

    usr_shift_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Shift register the sequencer controls, written from its select contract.
    logic [3:0] sr;
    always @(posedge clk) begin
        if (reset) sr <= 4'd0;
        else case (bus.usr_select)
            2'b01:   sr <= {bus.usr_shift_right, sr[3:1]};
            2'b10:   sr <= {sr[2:0], bus.usr_shift_left};
            2'b11:   sr <= bus.usr_parallel_in;
            default: sr <= sr;
        endcase
    end
    assign bus.usr_data_out = sr;

    // One command step in plain arithmetic.
    function automatic logic [3:0] model_step(input logic [1:0] op, input logic [3:0] v, input logic fill);
        int x;
        x = v;
        case (op)
            2'd0:    x = x / 2 + (fill ? 8 : 0);
            2'd1:    x = (x * 2) % 16 + (fill ? 1 : 0);
            2'd2:    x = x / 2 + (x % 2) * 8;
            default: x = (x * 2) % 16 + x / 8;
        endcase
        return 4'(x);
    endfunction

    function automatic logic [3:0] model_result(input logic [1:0] op, input logic [3:0] data,
                                                input int count, input logic fill);
        logic [3:0] v;
        v = data;
        for (int i = 0; i < count; i++) v = model_step(op, v, fill);
        return v;
    endfunction

    task automatic scramble_cmd();
        bus.cmd_valid = 1'($urandom_range(0, 1));
        bus.cmd_op    = 2'($urandom);
        bus.cmd_data  = 4'($urandom);
        bus.cmd_count = 3'($urandom);
        bus.cmd_fill  = 1'($urandom);
    endtask

    // Called at a negedge with the block idle; returns at a negedge with it idle again.
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] data, input int count,
                           input logic fill, input int hold, input logic [3:0] want, input string tag);
        logic [3:0] cur;
        logic [1:0] exp_sel;
        logic       exp_shr, exp_shl;
        cur = data;

        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s idle_ready: got %b want 1", tag, bus.cmd_ready);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        bus.cmd_count = 3'(count);
        bus.cmd_fill  = fill;
        @(negedge clk);
        scramble_cmd();

        checks++;
        if ({bus.usr_select, bus.usr_parallel_in, bus.cmd_ready, bus.rsp_valid} !== {2'b11, data, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL %s load: sel=%b pin=%b ready=%b rsp_valid=%b want sel=11 pin=%b ready=0 rsp_valid=0",
                     tag, bus.usr_select, bus.usr_parallel_in, bus.cmd_ready, bus.rsp_valid, data);
        end

        for (int i = 0; i < count; i++) begin
            @(negedge clk);
            scramble_cmd();
            exp_sel = op[0] ? 2'b10 : 2'b01;
            exp_shr = (op == 2'd0) ? fill : (op == 2'd2) ? cur[0] : 1'b0;
            exp_shl = (op == 2'd1) ? fill : (op == 2'd3) ? cur[3] : 1'b0;
            checks++;
            if ({bus.usr_select, bus.usr_shift_right, bus.usr_shift_left, bus.rsp_valid, bus.cmd_ready}
                !== {exp_sel, exp_shr, exp_shl, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL %s shift%0d: sel=%b sr=%b sl=%b rsp_valid=%b ready=%b want sel=%b sr=%b sl=%b 0 0",
                         tag, i, bus.usr_select, bus.usr_shift_right, bus.usr_shift_left,
                         bus.rsp_valid, bus.cmd_ready, exp_sel, exp_shr, exp_shl);
            end
            cur = model_step(op, cur, fill);
        end

        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            checks++;
            if ({bus.rsp_valid, bus.rsp_data, bus.usr_select, bus.cmd_ready} !== {1'b1, want, 2'b00, 1'b0}) begin
                failures++;
                $display("FAIL %s done%0d: rsp_valid=%b rsp_data=%b sel=%b ready=%b want 1 %b 00 0",
                         tag, h, bus.rsp_valid, bus.rsp_data, bus.usr_select, bus.cmd_ready, want);
            end
            bus.rsp_ready = (h == hold);
            if (h == hold) bus.cmd_valid = 1'b0;
            else scramble_cmd();
        end

        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b0;
        checks++;
        if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.usr_select, bus.usr_parallel_in,
             bus.usr_shift_right, bus.usr_shift_left} !== {1'b1, 1'b0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL %s back_idle: ready=%b rsp_valid=%b rsp_data=%b sel=%b pin=%b sr=%b sl=%b want 1 0 0 00 0 0 0",
                     tag, bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.usr_select,
                     bus.usr_parallel_in, bus.usr_shift_right, bus.usr_shift_left);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op = 2'd0; bus.cmd_data = 4'hF; bus.cmd_count = 3'd1; bus.cmd_fill = 1'b1;
        bus.rsp_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.usr_select, bus.usr_parallel_in,
                 bus.usr_shift_left, bus.usr_shift_right} !== 13'd0) begin
                failures++;
                $display("FAIL reset_outputs%0d: ready=%b rsp_valid=%b rsp_data=%b sel=%b pin=%b sl=%b sr=%b want all 0",
                         c, bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.usr_select,
                         bus.usr_parallel_in, bus.usr_shift_left, bus.usr_shift_right);
            end
        end
        reset = 1'b0;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b want 1", bus.cmd_ready);
        end
    endtask

    task automatic test_directed();
        run_cmd(2'b11, 4'b0110, 1, 1'b0, 0, 4'b1100, "rol_1");
        run_cmd(2'b00, 4'b0110, 2, 1'b1, 0, 4'b1101, "shr_fill1");
        run_cmd(2'b10, 4'b1001, 5, 1'b0, 0, 4'b1100, "ror_wrap");
        run_cmd(2'b01, 4'b0111, 3, 1'b0, 0, 4'b1000, "shl_fill0");
    endtask

    task automatic test_backpressure();
        run_cmd(2'b00, 4'b1010, 0, 1'b0, 3, 4'b1010, "count0_hold3");
    endtask

    task automatic test_back_to_back();
        run_cmd(2'b11, 4'b1000, 7, 1'b0, 0, 4'b0100, "b2b_a");
        run_cmd(2'b01, 4'b0001, 4, 1'b1, 1, 4'b1111, "b2b_b");
    endtask

    task automatic test_random();
        logic [1:0] op;
        logic [3:0] data;
        logic       fill;
        int         count, hold;
        for (int n = 0; n < 40; n++) begin
            op    = 2'($urandom);
            data  = 4'($urandom);
            fill  = 1'($urandom);
            count = $urandom_range(0, 7);
            hold  = $urandom_range(0, 3);
            run_cmd(op, data, count, fill, hold, model_result(op, data, count, fill), "random");
        end
    endtask

    task automatic test_reset_mid_shift();
        bus.cmd_valid = 1'b1;
        bus.cmd_op = 2'b00; bus.cmd_data = 4'b1111; bus.cmd_count = 3'd6; bus.cmd_fill = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.cmd_ready, bus.rsp_valid, bus.usr_select, bus.usr_shift_right} !== 5'd0) begin
            failures++;
            $display("FAIL midreset_outputs: ready=%b rsp_valid=%b sel=%b sr=%b want 0 0 00 0",
                     bus.cmd_ready, bus.rsp_valid, bus.usr_select, bus.usr_shift_right);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.cmd_ready, bus.rsp_valid, bus.usr_select} !== {1'b1, 1'b0, 2'b00}) begin
                failures++;
                $display("FAIL midreset_idle%0d: ready=%b rsp_valid=%b sel=%b want 1 0 00",
                         c, bus.cmd_ready, bus.rsp_valid, bus.usr_select);
            end
        end
        bus.rsp_ready = 1'b0;
        run_cmd(2'b10, 4'b0011, 1, 1'b0, 0, 4'b1001, "after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
